// File: rtl/uart_tx_tick.sv
// Serial frame transmitter paced by the rising edges of an external divided clock.
// Frames are start + DATA_W data bits (LSB first) + optional parity + STOP_BITS stop bits.
module uart_tx_tick #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_in,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  output logic              ready,
  output logic              tx,
  output logic              done
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [1:0]        r_scnt, w_scnt_nxt;
  logic              r_par, w_par_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_done, w_done_nxt;
  logic              r_baud_q;
  logic              w_tick;
  logic              w_par_calc;

  // baud_q resets high so a line already high at reset exit is not an edge
  assign w_tick     = baud_in & ~r_baud_q;
  assign w_par_calc = (PARITY == 2) ? ~(^data) : ^data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_scnt   <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_baud_q <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_cnt    <= w_cnt_nxt;
      r_scnt   <= w_scnt_nxt;
      r_par    <= w_par_nxt;
      r_tx     <= w_tx_nxt;
      r_ready  <= w_ready_nxt;
      r_done   <= w_done_nxt;
      r_baud_q <= baud_in;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_scnt_nxt  = r_scnt;
    w_par_nxt   = r_par;
    w_tx_nxt    = r_tx;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // a tick coinciding with accept is deliberately dropped
        if (r_ready && start) begin
          w_shift_nxt = data;
          w_par_nxt   = w_par_calc;
          w_ready_nxt = 1'b0;
          w_state_nxt = S_SYNC;
        end
      end
      S_SYNC: begin
        if (w_tick) begin
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          w_cnt_nxt   = CW'(1);
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_cnt < CW'(DATA_W)) begin
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
            w_cnt_nxt   = r_cnt + CW'(1);
          end else if (PARITY != 0) begin
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_par;
          end else begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
            w_scnt_nxt  = 2'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
          w_scnt_nxt  = 2'd1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_scnt < 2'(STOP_BITS)) begin
            w_scnt_nxt = r_scnt + 2'd1;
          end else begin
            w_state_nxt = S_IDLE;
            w_ready_nxt = 1'b1;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  assign tx    = r_tx;
  assign ready = r_ready;
  assign done  = r_done;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Scoreboard bench: stimulus queues hand-computed frames, a monitor samples tx mid-bit.
// Instances: 0 default, 1 even parity, 2 odd parity, 3 two stop bits.
module tb_uart_tx_tick;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] bcnt = 2'd0;
  logic       force_en, force_val;
  wire        baud_in;
  logic [3:0] start_v;
  logic [7:0] data_v [4];
  wire  [3:0] tx_v, ready_v, done_v;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en;
  bit mon_busy = 0;

  typedef struct {
    int          inst;
    logic [11:0] bits;   // bit j = j-th bit on the line (start first)
    int          nbits;
  } frm_t;
  frm_t exp_q[$];

  always #5 clk = ~clk;

  // divide-by-4 reference clock, like a divM #(4) output
  always @(posedge clk) bcnt <= bcnt + 2'd1;
  assign baud_in = force_en ? force_val : bcnt[1];

  uart_tx_tick u0 (.clk(clk), .rst(rst), .baud_in(baud_in), .data(data_v[0]),
                   .start(start_v[0]), .ready(ready_v[0]), .tx(tx_v[0]), .done(done_v[0]));
  uart_tx_tick #(.PARITY(1)) u1 (.clk(clk), .rst(rst), .baud_in(baud_in), .data(data_v[1]),
                   .start(start_v[1]), .ready(ready_v[1]), .tx(tx_v[1]), .done(done_v[1]));
  uart_tx_tick #(.PARITY(2)) u2 (.clk(clk), .rst(rst), .baud_in(baud_in), .data(data_v[2]),
                   .start(start_v[2]), .ready(ready_v[2]), .tx(tx_v[2]), .done(done_v[2]));
  uart_tx_tick #(.STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .baud_in(baud_in), .data(data_v[3]),
                   .start(start_v[3]), .ready(ready_v[3]), .tx(tx_v[3]), .done(done_v[3]));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic send(int inst, logic [7:0] d, logic [11:0] bits, int nb);
    exp_q.push_back('{inst, bits, nb});
    data_v[inst]  = d;
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
    data_v[inst]  = ~d;   // must not leak into the frame
    wait_idle();
  endtask

  // monitor: on a start-bit fall, sample each bit mid-period and check the done pulse
  initial begin
    logic [3:0]  prev;
    logic [11:0] got;
    frm_t        f;
    bit          rbad;
    int          n;
    prev = 4'hF;
    forever begin
      @(negedge clk);
      if (mon_en && exp_q.size() > 0 && prev[exp_q[0].inst] && !tx_v[exp_q[0].inst]) begin
        f = exp_q.pop_front();
        mon_busy = 1;
        got  = '0;
        rbad = 0;
        for (int j = 0; j < f.nbits; j++) begin
          repeat ((j == 0) ? 1 : 4) @(negedge clk);
          got[j] = tx_v[f.inst];
          if (ready_v[f.inst]) rbad = 1;
        end
        chk($sformatf("frame_u%0d", f.inst), 32'(got), 32'(f.bits));
        chk("ready_low_in_frame", 32'(rbad), 0);
        n = 0;
        while (!done_v[f.inst] && n < 8) begin
          @(negedge clk);
          n++;
        end
        chk("done_latency", n, 3);
        chk("ready_at_done", 32'(ready_v[f.inst]), 1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_v[f.inst]), 0);
        mon_busy = 0;
      end
      prev = tx_v;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  hit, pb;
    rst = 1'b1; force_en = 1'b0; force_val = 1'b1; mon_en = 1'b1;
    start_v = '0;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx_v[0]), 1);
    chk("rst_ready", 32'(ready_v[0]), 1);
    chk("rst_done", 32'(done_v[0]), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // A5 LSB first: 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5, 12'b00_1_10100101_0, 10);
    // A5 has four ones: even parity 0, odd parity 1
    send(1, 8'hA5, 12'b0_1_0_10100101_0, 11);
    send(2, 8'hA5, 12'b0_1_1_10100101_0, 11);

    // back-to-back with start held, two stop bits
    exp_q.push_back('{3, 12'b0_11_00000000_0, 11});
    data_v[3] = 8'h00; start_v[3] = 1'b1;
    @(negedge clk);
    chk("b2b_first_accept", 32'(ready_v[3]), 0);
    exp_q.push_back('{3, 12'b0_11_11111111_0, 11});
    data_v[3] = 8'hFF;
    n = 0;
    while (!ready_v[3] && n < 200) begin @(negedge clk); n++; end
    chk("b2b_ready_rise", 32'(ready_v[3]), 1);
    @(negedge clk);
    chk("b2b_next_accept", 32'(ready_v[3]), 0);
    start_v[3] = 1'b0; data_v[3] = 8'h55;
    wait_idle();

    // start on a tick cycle: tick dropped, start bit one period later
    pb = baud_in; n = 0;
    do begin
      @(negedge clk);
      hit = baud_in && !pb;
      pb  = baud_in;
      n++;
    end while (!hit && n < 16);
    exp_q.push_back('{0, 12'b00_1_10100101_0, 10});
    data_v[0] = 8'hA5; start_v[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start_v[0] = 1'b0;
      n++;
    end while (tx_v[0] && n < 20);
    chk("tick_on_accept_lat", n, 5);
    wait_idle();

    // reset during data bit 3 of 5A
    mon_en = 1'b0;
    data_v[0] = 8'h5A; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (tx_v[0] && n < 20) begin @(negedge clk); n++; end
    repeat (17) @(negedge clk);
    chk("mid_bit3", 32'(tx_v[0]), 1);
    chk("mid_ready", 32'(ready_v[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(tx_v[0]), 1);
    chk("abort_ready", 32'(ready_v[0]), 1);
    chk("abort_done", 32'(done_v[0]), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 8'h3C, 12'b00_1_00111100_0, 10);

    // baud held high across reset exit: no tick until a real rising edge
    mon_en = 1'b0;
    force_val = 1'b1; force_en = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    data_v[0] = 8'hA5; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("stuck_high_tx", 32'(tx_v[0]), 1);
    chk("stuck_high_wait", 32'(ready_v[0]), 0);
    force_val = 1'b0;
    repeat (2) @(negedge clk);
    chk("stuck_low_tx", 32'(tx_v[0]), 1);
    force_val = 1'b1;
    @(negedge clk);
    chk("first_real_edge", 32'(tx_v[0]), 0);
    force_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    send(0, 8'hA5, 12'b00_1_10100101_0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
